// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register for the multistage MIPS datapath.
// Captures the ALU result, store data and MEM/WB controls from EX, and
// applies stall (hold) and flush (bubble).
// Optional feature, enabled by defining EX_MEM_ALIGN_CHECK_EN: misaligned
// loads/stores are trapped before they reach the data memory. The trapping
// access is replaced by a bubble, and an IDLE/TRAP FSM squashes everything
// that follows until exc_ack arrives.
module ex_mem_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        exc_ack,
    input  logic [31:0] alu_result,
    input  logic [31:0] register_out2,
    input  logic [31:0] pc,
    input  logic [1:0]  LS_bit,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        Ext_op,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [4:0]  write_reg,
    output logic [31:0] EX_MEM_alu_out,
    output logic [31:0] EX_MEM_register_out2,
    output logic [1:0]  EX_MEM_LS_bit,
    output logic [4:0]  EX_MEM_write_reg,
    output logic        EX_MEM_MemWrite,
    output logic        EX_MEM_MemRead,
    output logic        EX_MEM_Ext_op,
    output logic        EX_MEM_RegWrite,
    output logic        EX_MEM_MemtoReg,
    output logic        EX_MEM_valid,
    output logic        align_exc,
    output logic [31:0] exc_pc
);

    // High when the instruction arriving from EX must become a bubble
    // because of an alignment trap (new or already pending).
    logic squash;

`ifdef EX_MEM_ALIGN_CHECK_EN
    typedef enum logic {
        IDLE = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t state;
    logic   misaligned;

    // Reserved size code 11 counts as misaligned at any address.
    function automatic logic is_misaligned(input logic       access,
                                           input logic [1:0] ls,
                                           input logic [1:0] addr_lo);
        if (!access) begin
            return 1'b0;
        end
        case (ls)
            2'b00:   return (addr_lo != 2'b00);
            2'b01:   return addr_lo[0];
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign misaligned = is_misaligned(MemRead | MemWrite, LS_bit, alu_result[1:0]);

    // A stalled misaligned access is not captured, so it does not squash yet.
    assign squash = (state == TRAP) || (misaligned && !stall);

    // Trap FSM: enter TRAP on a real capture of a misaligned access,
    // leave on exc_ack regardless of stall/flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            align_exc <= 1'b0;
            exc_pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && !stall && misaligned) begin
                        state     <= TRAP;
                        align_exc <= 1'b1;
                        exc_pc    <= pc;
                    end
                end
                TRAP: begin
                    if (exc_ack) begin
                        state     <= IDLE;
                        align_exc <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    align_exc <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{exc_ack, pc};
    assign squash        = 1'b0;
    assign align_exc     = 1'b0;
    assign exc_pc        = RESET_PC;
`endif

    // Pipeline register: flush/squash load a bubble, stall holds, else capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            EX_MEM_alu_out       <= 32'h0;
            EX_MEM_register_out2 <= 32'h0;
            EX_MEM_LS_bit        <= 2'b00;
            EX_MEM_write_reg     <= 5'd0;
            EX_MEM_MemWrite      <= 1'b0;
            EX_MEM_MemRead       <= 1'b0;
            EX_MEM_Ext_op        <= 1'b0;
            EX_MEM_RegWrite      <= 1'b0;
            EX_MEM_MemtoReg      <= 1'b0;
            EX_MEM_valid         <= 1'b0;
        end else if (flush || squash) begin
            EX_MEM_alu_out       <= 32'h0;
            EX_MEM_register_out2 <= 32'h0;
            EX_MEM_LS_bit        <= 2'b00;
            EX_MEM_write_reg     <= 5'd0;
            EX_MEM_MemWrite      <= 1'b0;
            EX_MEM_MemRead       <= 1'b0;
            EX_MEM_Ext_op        <= 1'b0;
            EX_MEM_RegWrite      <= 1'b0;
            EX_MEM_MemtoReg      <= 1'b0;
            EX_MEM_valid         <= 1'b0;
        end else if (!stall) begin
            EX_MEM_alu_out       <= alu_result;
            EX_MEM_register_out2 <= register_out2;
            EX_MEM_LS_bit        <= LS_bit;
            EX_MEM_write_reg     <= write_reg;
            EX_MEM_MemWrite      <= MemWrite;
            EX_MEM_MemRead       <= MemRead;
            EX_MEM_Ext_op        <= Ext_op;
            EX_MEM_RegWrite      <= RegWrite;
            EX_MEM_MemtoReg      <= MemtoReg;
            EX_MEM_valid         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed test-plan scenarios plus randomized traffic for
// ex_mem_reg, checked against a behavioural model of the register/trap rules.
// Follows EX_MEM_ALIGN_CHECK_EN the same way the design does.
module tb_ex_mem_reg;

`ifdef EX_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, exc_ack = 1'b0;
    logic [31:0] alu_result = '0, register_out2 = '0, pc = '0;
    logic [1:0]  LS_bit = '0;
    logic        MemWrite = 1'b0, MemRead = 1'b0, Ext_op = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] EX_MEM_alu_out, EX_MEM_register_out2, exc_pc;
    logic [1:0]  EX_MEM_LS_bit;
    logic [4:0]  EX_MEM_write_reg;
    logic        EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_Ext_op, EX_MEM_RegWrite, EX_MEM_MemtoReg;
    logic        EX_MEM_valid, align_exc;

    int n_chk = 0;
    int n_err = 0;

    ex_mem_reg #(.RESET_PC(RST_PC)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .alu_result(alu_result), .register_out2(register_out2), .pc(pc), .LS_bit(LS_bit),
        .MemWrite(MemWrite), .MemRead(MemRead), .Ext_op(Ext_op), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .write_reg(write_reg),
        .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_register_out2(EX_MEM_register_out2),
        .EX_MEM_LS_bit(EX_MEM_LS_bit), .EX_MEM_write_reg(EX_MEM_write_reg),
        .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_Ext_op(EX_MEM_Ext_op), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_valid(EX_MEM_valid),
        .align_exc(align_exc), .exc_pc(exc_pc)
    );

    always #5 clock = ~clock;

    // Reference model state: what the EX/MEM entry and trap status should be.
    typedef struct {
        logic [31:0] alu, rd2;
        logic [1:0]  ls;
        logic [4:0]  wr;
        logic        mw, mr, ext, rw, m2r, valid;
    } entry_t;

    entry_t      m_e;
    logic        m_trap;
    logic [31:0] m_epc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e    = '{alu: '0, rd2: '0, ls: '0, wr: '0, mw: 0, mr: 0, ext: 0, rw: 0, m2r: 0, valid: 0};
        m_trap = 1'b0;
        m_epc  = RST_PC;
    endtask

    // One clock edge of the model, from the inputs present at that edge.
    task automatic model_step();
        bit mis, bubble;
        mis = ALIGN && (MemRead || MemWrite) &&
              (LS_bit == 2'd3 ||
               (LS_bit == 2'd0 && (alu_result % 4) != 0) ||
               (LS_bit == 2'd1 && (alu_result % 2) != 0));
        bubble = flush || m_trap || (!stall && mis);
        if (bubble)
            m_e = '{alu: '0, rd2: '0, ls: '0, wr: '0, mw: 0, mr: 0, ext: 0, rw: 0, m2r: 0, valid: 0};
        else if (!stall)
            m_e = '{alu: alu_result, rd2: register_out2, ls: LS_bit, wr: write_reg, mw: MemWrite,
                    mr: MemRead, ext: Ext_op, rw: RegWrite, m2r: MemtoReg, valid: 1'b1};
        if (m_trap) begin
            if (exc_ack) m_trap = 1'b0;
        end else if (!flush && !stall && mis) begin
            m_trap = 1'b1;
            m_epc  = pc;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alu"},   EX_MEM_alu_out, m_e.alu);
        chk({tag, ".rd2"},   EX_MEM_register_out2, m_e.rd2);
        chk({tag, ".ls"},    32'(EX_MEM_LS_bit), 32'(m_e.ls));
        chk({tag, ".wr"},    32'(EX_MEM_write_reg), 32'(m_e.wr));
        chk({tag, ".ctl"},   32'({EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_Ext_op, EX_MEM_RegWrite, EX_MEM_MemtoReg}),
                             32'({m_e.mw, m_e.mr, m_e.ext, m_e.rw, m_e.m2r}));
        chk({tag, ".valid"}, 32'(EX_MEM_valid), 32'(m_e.valid));
        chk({tag, ".exc"},   32'(align_exc), 32'(m_trap));
        chk({tag, ".epc"},   exc_pc, m_epc);
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] ls, input logic mw,
                         input logic mr, input logic [31:0] p);
        alu_result = a; LS_bit = ls; MemWrite = mw; MemRead = mr; pc = p;
        register_out2 = $urandom; write_reg = 5'($urandom); RegWrite = 1'($urandom);
        Ext_op = 1'($urandom); MemtoReg = 1'($urandom);
    endtask

    task automatic do_ack();
        drive(32'h100, 2'b00, 1'b0, 1'b0, 32'h200);
        exc_ack = 1'b1;
        tick("ack");
        chk("ack_clears", 32'(align_exc), 32'h0);
        exc_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check_all("rst0");

        // Reset and first capture
        @(negedge clock);
        reset_n = 1'b1;
        drive(32'h10, 2'b00, 1'b1, 1'b0, 32'h20);
        register_out2 = 32'hDEADBEEF;
        tick("first");
        chk("first_alu", EX_MEM_alu_out, 32'h10);
        chk("first_mw", 32'(EX_MEM_MemWrite), 32'h1);
        chk("first_valid", 32'(EX_MEM_valid), 32'h1);

        // Mid-cycle asynchronous reset
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        reset_n = 1'b1;

        // Stall holds, stall+flush gives bubble
        drive(32'h44, 2'b10, 1'b0, 1'b0, 32'h30);
        write_reg = 5'd5; RegWrite = 1'b1;
        tick("cap5");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h50 + 32'(i), 2'b00, 1'b0, 1'b1, 32'h34);
            tick("stall");
            chk("stall_wr", 32'(EX_MEM_write_reg), 32'd5);
        end
        flush = 1'b1;
        tick("stflush");
        chk("stflush_valid", 32'(EX_MEM_valid), 32'h0);
        chk("stflush_rw", 32'(EX_MEM_RegWrite), 32'h0);
        stall = 1'b0; flush = 1'b0;

        // Misaligned word store
        drive(32'h6, 2'b00, 1'b1, 1'b0, 32'h40);
        tick("mis_st");
        chk("mis_mw", 32'(EX_MEM_MemWrite), ALIGN ? 32'h0 : 32'h1);
        chk("mis_alu", EX_MEM_alu_out, ALIGN ? 32'h0 : 32'h6);
        chk("mis_exc", 32'(align_exc), ALIGN ? 32'h1 : 32'h0);
        chk("mis_epc", exc_pc, ALIGN ? 32'h40 : RST_PC);
        for (int i = 0; i < 2; i++) begin
            drive(32'h80, 2'b00, 1'b0, 1'b1, 32'h44 + 32'(4 * i));
            tick("squash");
            chk("squash_valid", 32'(EX_MEM_valid), ALIGN ? 32'h0 : 32'h1);
        end
        do_ack();
        drive(32'h84, 2'b00, 1'b0, 1'b1, 32'h50);
        tick("post_ack");
        chk("post_ack_valid", 32'(EX_MEM_valid), 32'h1);

        // Alignment boundaries
        drive(32'h2, 2'b01, 1'b0, 1'b1, 32'h60);
        tick("half2");
        chk("half2_exc", 32'(align_exc), 32'h0);
        drive(32'h3, 2'b01, 1'b0, 1'b1, 32'h64);
        tick("half3");
        chk("half3_exc", 32'(align_exc), ALIGN ? 32'h1 : 32'h0);
        do_ack();
        drive(32'h3, 2'b10, 1'b1, 1'b0, 32'h68);
        tick("byte3");
        chk("byte3_valid", 32'(EX_MEM_valid), 32'h1);
        drive(32'h8, 2'b11, 1'b0, 1'b1, 32'h6C);
        tick("rsv_rd");
        chk("rsv_rd_exc", 32'(align_exc), ALIGN ? 32'h1 : 32'h0);
        do_ack();
        drive(32'h9, 2'b11, 1'b0, 1'b0, 32'h70);
        tick("rsv_nomem");
        chk("rsv_nomem_valid", 32'(EX_MEM_valid), 32'h1);

        // Trap while stalled
        stall = 1'b1;
        drive(32'h5, 2'b00, 1'b0, 1'b1, 32'h74);
        tick("mis_stalled");
        chk("mis_stalled_exc", 32'(align_exc), 32'h0);
        stall = 1'b0;
        tick("mis_unstall");
        chk("mis_unstall_exc", 32'(align_exc), ALIGN ? 32'h1 : 32'h0);
        chk("mis_unstall_epc", exc_pc, ALIGN ? 32'h74 : RST_PC);
        stall = 1'b1; exc_ack = 1'b1;
        drive(32'h0, 2'b00, 1'b0, 1'b0, 32'h78);
        tick("ack_stalled");
        chk("ack_stalled_exc", 32'(align_exc), 32'h0);
        stall = 1'b0; exc_ack = 1'b0;

        // Flush in TRAP keeps the trap; reset mid-trap clears it at once
        drive(32'h1, 2'b00, 1'b1, 1'b0, 32'h90);
        tick("trap2");
        flush = 1'b1;
        tick("trap_flush");
        chk("trap_flush_exc", 32'(align_exc), ALIGN ? 32'h1 : 32'h0);
        flush = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_trap");
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom, 2'($urandom), 1'($urandom), 1'($urandom), $urandom);
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            exc_ack = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
